card_system: RTL and testbench

Blackjack card-dealing subsystem, made of a deck/puller stage and a hand-manager stage.
- On a user request it deals one card, without replacement, from a 52-card deck.
- It adds the card value to that user's running high/low hand totals.
- Hands exist for player 1, player 2 and the dealer.
- It sits between the game-control FSM, which drives userSelect, and the display/score logic, which consumes the hand totals.

---
 rtl/card_if.sv | 29 ++
 rtl/card_system.sv | 230 +++++++++++++++++++++++
 tb/tb_card_system.sv | 394 +++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/card_if.sv
// card_if: request/result bundle between the game-control FSM, the card dealer
// and the display/score logic.
//   userSelect   [1:0] hand requesting a card (0 idle, 1 player 1, 2 player 2, 3 dealer)
//   card         [3:0] dealt card value 1..10, 0 when no card is presented
//   cardsUpdated       one-cycle pulse in the cycle a hand total changes
//   p1_high/p1_low, p2_high/p2_low, d_high/d_low [5:0]
//                      hand totals with ace counted as 11 (high) or as 1 (low)
// master: the requesting side (game control / bench); slave: the dealer.
interface card_if;
  logic [1:0] userSelect;
  logic [3:0] card;
  logic       cardsUpdated;
  logic [5:0] p1_high;
  logic [5:0] p1_low;
  logic [5:0] p2_high;
  logic [5:0] p2_low;
  logic [5:0] d_high;
  logic [5:0] d_low;

  modport master (
    output userSelect,
    input  card, cardsUpdated, p1_high, p1_low, p2_high, p2_low, d_high, d_low
  );

  modport slave (
    input  userSelect,
    output card, cardsUpdated, p1_high, p1_low, p2_high, p2_low, d_high, d_low
  );
endinterface

// File: rtl/card_system.sv
// card_system: blackjack card dealer. A puller deals one card per request,
// without replacement, from a 52-slot deck; a hand manager accumulates the
// card into the requesting hand's high (ace = 11) and low (ace = 1) totals.
// Ports:
//   clk    system clock, all state changes on the rising edge
//   reset  synchronous active-high reset
//   bus    card_if.slave: userSelect in; card, cardsUpdated and the six totals out
module card_system #(
  parameter logic [7:0] LFSR_SEED = 8'hA5
) (
  input  logic  clk,
  input  logic  reset,
  card_if.slave bus
);

  localparam logic [5:0] LAST_SLOT = 6'd51;

  typedef enum logic [1:0] {
    IDLE         = 2'd0,
    SEARCH       = 2'd1,
    WAIT_RELEASE = 2'd2
  } pullState_t;

  pullState_t  state_r;
  pullState_t  nextState_s;
  logic [7:0]  lfsr_r;
  logic [5:0]  scanPtr_r;
  logic [5:0]  nextPtr_s;
  logic [5:0]  missCnt_r;
  logic [5:0]  nextMiss_s;
  logic [51:0] dealt_r;
  logic        dealNow_s;
  logic [3:0]  card_r;
  logic        cardsUpdated_r;
  logic [5:0]  p1High_r;
  logic [5:0]  p1Low_r;
  logic [5:0]  p2High_r;
  logic [5:0]  p2Low_r;
  logic [5:0]  dHigh_r;
  logic [5:0]  dLow_r;
  logic [5:0]  selHigh_s;
  logic [5:0]  selLow_s;
  logic [5:0]  newHigh_s;
  logic [5:0]  newLow_s;
  logic        handChange_s;

  // Slots 0..35 hold four each of 1..9; slots 36..51 are the sixteen tens.
  function automatic logic [3:0] slotValue(input logic [5:0] idx);
    if (idx >= 6'd36) begin
      return 4'd10;
    end else begin
      return idx[5:2] + 4'd1;
    end
  endfunction

  // Three conditional subtractions reduce any 8-bit value into 0..51.
  function automatic logic [5:0] mod52(input logic [7:0] v);
    logic [7:0] r;
    r = v;
    r = (r >= 8'd208) ? (r - 8'd208) : r;
    r = (r >= 8'd104) ? (r - 8'd104) : r;
    r = (r >= 8'd52)  ? (r - 8'd52)  : r;
    return r[5:0];
  endfunction

  // Fibonacci LFSR, taps x^8+x^6+x^5+x^4+1 (maximal length, never reaches zero).
  function automatic logic [7:0] lfsrStep(input logic [7:0] s);
    return {s[6:0], s[7] ^ s[5] ^ s[4] ^ s[3]};
  endfunction

  // High total: ace counts 11; a total already above 21 is frozen.
  function automatic logic [5:0] addHigh(input logic [5:0] h, input logic [3:0] c);
    if (h > 6'd21) begin
      return h;
    end else if (c == 4'd1) begin
      return h + 6'd11;
    end else begin
      return h + {2'b00, c};
    end
  endfunction

  // Low total: only starts counting once an ace has been seen (first ace -> 1).
  function automatic logic [5:0] addLow(input logic [5:0] l, input logic [3:0] c);
    if (l > 6'd21) begin
      return l;
    end else if (c == 4'd1) begin
      return l + 6'd1;
    end else if (l == 6'd0) begin
      return l;
    end else begin
      return l + {2'b00, c};
    end
  endfunction

  // Puller next-state: start a scan at a random slot, walk until an undealt slot or a full lap.
  always_comb begin
    nextState_s = state_r;
    nextPtr_s   = scanPtr_r;
    nextMiss_s  = missCnt_r;
    dealNow_s   = 1'b0;
    case (state_r)
      IDLE: begin
        if (bus.userSelect != 2'd0) begin
          nextState_s = SEARCH;
          nextPtr_s   = mod52(lfsr_r);
          nextMiss_s  = 6'd0;
        end else begin
          nextState_s = IDLE;
        end
      end
      SEARCH: begin
        if (bus.userSelect == 2'd0) begin
          nextState_s = IDLE;
        end else if (!dealt_r[scanPtr_r]) begin
          dealNow_s   = 1'b1;
          nextState_s = WAIT_RELEASE;
        end else if (missCnt_r == LAST_SLOT) begin
          // Every slot visited without a hit: the deck is empty.
          nextState_s = WAIT_RELEASE;
        end else begin
          nextMiss_s = missCnt_r + 6'd1;
          nextPtr_s  = (scanPtr_r == LAST_SLOT) ? 6'd0 : (scanPtr_r + 6'd1);
        end
      end
      WAIT_RELEASE: begin
        if (bus.userSelect == 2'd0) begin
          nextState_s = IDLE;
        end else begin
          nextState_s = WAIT_RELEASE;
        end
      end
      default: begin
        nextState_s = IDLE;
      end
    endcase
  end

  // Puller state, LFSR, deck bookkeeping and the registered card pulse.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r   <= IDLE;
      lfsr_r    <= LFSR_SEED;
      scanPtr_r <= 6'd0;
      missCnt_r <= 6'd0;
      dealt_r   <= 52'd0;
      card_r    <= 4'd0;
    end else begin
      state_r   <= nextState_s;
      lfsr_r    <= lfsrStep(lfsr_r);
      scanPtr_r <= nextPtr_s;
      missCnt_r <= nextMiss_s;
      dealt_r   <= dealt_r | (dealNow_s ? (52'd1 << scanPtr_r) : 52'd0);
      card_r    <= dealNow_s ? slotValue(scanPtr_r) : 4'd0;
    end
  end

  // Manager: pick the requesting hand and compute its updated totals.
  always_comb begin
    selHigh_s = 6'd0;
    selLow_s  = 6'd0;
    case (bus.userSelect)
      2'd1: begin
        selHigh_s = p1High_r;
        selLow_s  = p1Low_r;
      end
      2'd2: begin
        selHigh_s = p2High_r;
        selLow_s  = p2Low_r;
      end
      2'd3: begin
        selHigh_s = dHigh_r;
        selLow_s  = dLow_r;
      end
      default: begin
        selHigh_s = 6'd0;
        selLow_s  = 6'd0;
      end
    endcase
    newHigh_s = addHigh(selHigh_s, card_r);
    newLow_s  = addLow(selLow_s, card_r);
    if ((card_r != 4'd0) && (bus.userSelect != 2'd0)) begin
      handChange_s = (newHigh_s != selHigh_s) || (newLow_s != selLow_s);
    end else begin
      handChange_s = 1'b0;
    end
  end

  // Manager: hand total registers and the change pulse.
  always_ff @(posedge clk) begin
    if (reset) begin
      cardsUpdated_r <= 1'b0;
      p1High_r       <= 6'd0;
      p1Low_r        <= 6'd0;
      p2High_r       <= 6'd0;
      p2Low_r        <= 6'd0;
      dHigh_r        <= 6'd0;
      dLow_r         <= 6'd0;
    end else begin
      cardsUpdated_r <= handChange_s;
      if (card_r != 4'd0) begin
        case (bus.userSelect)
          2'd1: begin
            p1High_r <= newHigh_s;
            p1Low_r  <= newLow_s;
          end
          2'd2: begin
            p2High_r <= newHigh_s;
            p2Low_r  <= newLow_s;
          end
          2'd3: begin
            dHigh_r <= newHigh_s;
            dLow_r  <= newLow_s;
          end
          default: begin
          end
        endcase
      end
    end
  end

  assign bus.card         = card_r;
  assign bus.cardsUpdated = cardsUpdated_r;
  assign bus.p1_high      = p1High_r;
  assign bus.p1_low       = p1Low_r;
  assign bus.p2_high      = p2High_r;
  assign bus.p2_low       = p2Low_r;
  assign bus.d_high       = dHigh_r;
  assign bus.d_low        = dLow_r;

endmodule

// File: tb/tb_card_system.sv
// tb_card_system: self-checking bench for card_system. Cards drawn by the DUT
// are random; the bench scores them with its own hand model and deck tally.
// Directed hands are built by discarding unwanted cards (userSelect dropped to
// 0 while the card is presented) until the wanted value comes out.
module tb_card_system;
  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;
  logic [5:0] mH [1:3];
  logic [5:0] mL [1:3];

  card_if bus();

  card_system #(.LFSR_SEED(8'hA5)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  function automatic logic [5:0] hiOf(input int u);
    case (u)
      1: return bus.p1_high;
      2: return bus.p2_high;
      default: return bus.d_high;
    endcase
  endfunction

  function automatic logic [5:0] loOf(input int u);
    case (u)
      1: return bus.p1_low;
      2: return bus.p2_low;
      default: return bus.d_low;
    endcase
  endfunction

  task automatic tick();
    @(negedge clk);
  endtask

  function automatic void modelClear();
    for (int u = 1; u <= 3; u++) begin
      mH[u] = 6'd0;
      mL[u] = 6'd0;
    end
  endfunction

  // Blackjack totals: a total above 21 stops moving; low only counts after an ace.
  function automatic bit modelAdd(input int u, input int c);
    int h;
    int l;
    bit changed;
    h = int'(mH[u]);
    l = int'(mL[u]);
    if (h <= 21) h = h + ((c == 1) ? 11 : c);
    if ((l <= 21) && ((c == 1) || (l != 0))) l = l + c;
    changed = (h != int'(mH[u])) || (l != int'(mL[u]));
    mH[u] = 6'(h);
    mL[u] = 6'(l);
    return changed;
  endfunction

  task automatic doReset();
    reset = 1'b1;
    bus.userSelect = 2'd0;
    tick();
    tick();
    reset = 1'b0;
    modelClear();
  endtask

  // Advance until a card is presented (bounded); leaves the bench at that cycle.
  task automatic waitCard(output int v, output bit ok);
    v = 0;
    ok = 1'b0;
    for (int i = 0; i < 60; i++) begin
      tick();
      if (bus.card !== 4'd0) begin
        v = int'(bus.card);
        ok = 1'b1;
        return;
      end
    end
  endtask

  // Draw cards for hand u, discarding until value 'want' is consumed by that hand.
  task automatic fish(input int u, input int want, output bit ok, output int spurious);
    int v;
    bit got;
    ok = 1'b0;
    spurious = 0;
    for (int a = 0; a < 52; a++) begin
      bus.userSelect = 2'(u);
      waitCard(v, got);
      if (!got) return;
      if (v == want) begin
        tick();
        ok = 1'b1;
        return;
      end
      bus.userSelect = 2'd0;
      tick();
      if (bus.cardsUpdated !== 1'b0) spurious++;
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    bus.userSelect = 2'd0;
    tick();
    tick();
    checks++;
    if (bus.card !== 4'd0 || bus.cardsUpdated !== 1'b0) begin
      errors++;
      $display("FAIL reset_outputs: card=%0d upd=%b expected 0/0", bus.card, bus.cardsUpdated);
    end
    for (int u = 1; u <= 3; u++) begin
      checks++;
      if (hiOf(u) !== 6'd0 || loOf(u) !== 6'd0) begin
        errors++;
        $display("FAIL reset_totals hand%0d: high=%0d low=%0d expected 0/0", u, hiOf(u), loOf(u));
      end
    end
    reset = 1'b0;
    modelClear();
  endtask

  task automatic test_first_deal();
    int v;
    bit ok;
    logic [5:0] eh;
    logic [5:0] el;
    bus.userSelect = 2'd1;
    tick();
    checks++;
    if (bus.card !== 4'd0) begin
      errors++;
      $display("FAIL first_edge_card: got %0d expected 0", bus.card);
    end
    waitCard(v, ok);
    checks++;
    if (!ok || v < 1 || v > 10) begin
      errors++;
      $display("FAIL first_card: ok=%0b value=%0d expected 1..10 within 60 edges", ok, v);
    end
    if (ok) begin
      tick();
      eh = (v == 1) ? 6'd11 : 6'(v);
      el = (v == 1) ? 6'd1 : 6'd0;
      checks++;
      if (bus.card !== 4'd0 || bus.cardsUpdated !== 1'b1) begin
        errors++;
        $display("FAIL first_pulse: card=%0d upd=%b expected 0/1", bus.card, bus.cardsUpdated);
      end
      checks++;
      if (bus.p1_high !== eh || bus.p1_low !== el) begin
        errors++;
        $display("FAIL first_p1: high=%0d low=%0d expected %0d/%0d", bus.p1_high, bus.p1_low, eh, el);
      end
      checks++;
      if ((bus.p2_high | bus.p2_low | bus.d_high | bus.d_low) !== 6'd0) begin
        errors++;
        $display("FAIL first_others: p2=%0d/%0d d=%0d/%0d expected all 0", bus.p2_high, bus.p2_low, bus.d_high, bus.d_low);
      end
      tick();
      checks++;
      if (bus.cardsUpdated !== 1'b0 || bus.card !== 4'd0) begin
        errors++;
        $display("FAIL first_after: card=%0d upd=%b expected 0/0", bus.card, bus.cardsUpdated);
      end
    end
    bus.userSelect = 2'd0;
    tick();
  endtask

  task automatic test_reset_mid_search();
    bus.userSelect = 2'd3;
    tick();
    reset = 1'b1;
    bus.userSelect = 2'd0;
    tick();
    checks++;
    if (bus.card !== 4'd0 || bus.cardsUpdated !== 1'b0) begin
      errors++;
      $display("FAIL midreset_card: card=%0d upd=%b expected 0/0", bus.card, bus.cardsUpdated);
    end
    for (int u = 1; u <= 3; u++) begin
      checks++;
      if (hiOf(u) !== 6'd0 || loOf(u) !== 6'd0) begin
        errors++;
        $display("FAIL midreset_totals hand%0d: high=%0d low=%0d expected 0/0", u, hiOf(u), loOf(u));
      end
    end
    reset = 1'b0;
    modelClear();
  endtask

  // Deals the whole deck (which the preceding reset must have refilled).
  task automatic test_full_deck();
    int counts [1:10];
    int v;
    int u;
    int extra;
    int second;
    bit ok;
    bit changed;
    for (int k = 1; k <= 10; k++) counts[k] = 0;
    second = 0;
    for (int n = 0; n < 52; n++) begin
      u = int'($urandom_range(3, 1));
      bus.userSelect = 2'(u);
      waitCard(v, ok);
      checks++;
      if (!ok || v < 1 || v > 10) begin
        errors++;
        $display("FAIL deck_pull %0d: ok=%0b value=%0d expected 1..10", n, ok, v);
        break;
      end
      counts[v]++;
      changed = modelAdd(u, v);
      tick();
      checks++;
      if (bus.card !== 4'd0 || bus.cardsUpdated !== changed) begin
        errors++;
        $display("FAIL deck_pulse %0d: card=%0d upd=%b expected 0/%b", n, bus.card, bus.cardsUpdated, changed);
      end
      for (int h = 1; h <= 3; h++) begin
        checks++;
        if (hiOf(h) !== mH[h] || loOf(h) !== mL[h]) begin
          errors++;
          $display("FAIL deck_totals pull%0d hand%0d: %0d/%0d expected %0d/%0d", n, h, hiOf(h), loOf(h), mH[h], mL[h]);
        end
      end
      extra = int'($urandom_range(3, 0));
      for (int e = 0; e < extra; e++) begin
        tick();
        if (bus.card !== 4'd0) second++;
      end
      bus.userSelect = 2'd0;
      tick();
    end
    checks++;
    if (second != 0) begin
      errors++;
      $display("FAIL deck_hold: %0d extra card cycles while held, expected 0", second);
    end
    for (int k = 1; k <= 10; k++) begin
      checks++;
      if (counts[k] != ((k == 10) ? 16 : 4)) begin
        errors++;
        $display("FAIL deck_count value%0d: got %0d expected %0d", k, counts[k], (k == 10) ? 16 : 4);
      end
    end
  endtask

  task automatic test_exhausted();
    int bad;
    bad = 0;
    bus.userSelect = 2'($urandom_range(3, 1));
    for (int i = 0; i < 60; i++) begin
      tick();
      if (bus.card !== 4'd0 || bus.cardsUpdated !== 1'b0) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL empty_deck: %0d cycles with card/update activity, expected 0", bad);
    end
    for (int h = 1; h <= 3; h++) begin
      checks++;
      if (hiOf(h) !== mH[h] || loOf(h) !== mL[h]) begin
        errors++;
        $display("FAIL empty_totals hand%0d: %0d/%0d expected %0d/%0d", h, hiOf(h), loOf(h), mH[h], mL[h]);
      end
    end
    bus.userSelect = 2'd0;
    tick();
  endtask

  task automatic test_freeze();
    int want [4] = '{10, 10, 5, 9};
    int expH [4] = '{10, 20, 25, 25};
    bit ok;
    bit chg;
    int sp;
    doReset();
    for (int i = 0; i < 4; i++) begin
      fish(1, want[i], ok, sp);
      chg = modelAdd(1, want[i]);
      checks++;
      if (!ok || sp != 0) begin
        errors++;
        $display("FAIL freeze_draw %0d: found=%0b spurious=%0d expected 1/0", i, ok, sp);
      end
      checks++;
      if (bus.p1_high !== 6'(expH[i]) || bus.p1_low !== 6'd0) begin
        errors++;
        $display("FAIL freeze_p1 %0d: high=%0d low=%0d expected %0d/0", i, bus.p1_high, bus.p1_low, expH[i]);
      end
      checks++;
      if (bus.cardsUpdated !== chg) begin
        errors++;
        $display("FAIL freeze_upd %0d: upd=%b expected %b", i, bus.cardsUpdated, chg);
      end
      bus.userSelect = 2'd0;
      tick();
    end
    checks++;
    if ((bus.p2_high | bus.p2_low | bus.d_high | bus.d_low) !== 6'd0) begin
      errors++;
      $display("FAIL freeze_others: p2=%0d/%0d d=%0d/%0d expected all 0", bus.p2_high, bus.p2_low, bus.d_high, bus.d_low);
    end
  endtask

  task automatic test_dealer();
    int want [3] = '{9, 1, 5};
    int expH [3] = '{9, 20, 25};
    int expL [3] = '{0, 1, 6};
    bit ok;
    int sp;
    doReset();
    for (int i = 0; i < 3; i++) begin
      fish(3, want[i], ok, sp);
      checks++;
      if (!ok || sp != 0) begin
        errors++;
        $display("FAIL dealer_draw %0d: found=%0b spurious=%0d expected 1/0", i, ok, sp);
      end
      checks++;
      if (bus.d_high !== 6'(expH[i]) || bus.d_low !== 6'(expL[i]) || bus.cardsUpdated !== 1'b1) begin
        errors++;
        $display("FAIL dealer_totals %0d: high=%0d low=%0d upd=%b expected %0d/%0d/1", i, bus.d_high, bus.d_low, bus.cardsUpdated, expH[i], expL[i]);
      end
      bus.userSelect = 2'd0;
      tick();
    end
    checks++;
    if ((bus.p1_high | bus.p1_low | bus.p2_high | bus.p2_low) !== 6'd0) begin
      errors++;
      $display("FAIL dealer_others: p1=%0d/%0d p2=%0d/%0d expected all 0", bus.p1_high, bus.p1_low, bus.p2_high, bus.p2_low);
    end
  endtask

  task automatic test_hold();
    int pulses;
    int v;
    bit chg;
    doReset();
    pulses = 0;
    v = 0;
    bus.userSelect = 2'd2;
    for (int i = 0; i < 100; i++) begin
      tick();
      if (bus.card !== 4'd0) begin
        pulses++;
        v = int'(bus.card);
      end
    end
    checks++;
    if (pulses != 1) begin
      errors++;
      $display("FAIL hold_pulses: got %0d card pulses expected 1", pulses);
    end
    if (pulses == 1) begin
      chg = modelAdd(2, v);
      checks++;
      if (bus.p2_high !== mH[2] || bus.p2_low !== mL[2]) begin
        errors++;
        $display("FAIL hold_p2: %0d/%0d expected %0d/%0d", bus.p2_high, bus.p2_low, mH[2], mL[2]);
      end
    end
    bus.userSelect = 2'd0;
    tick();
  endtask

  initial begin
    reset = 1'b1;
    bus.userSelect = 2'd0;
    modelClear();
    test_reset();
    test_first_deal();
    test_reset_mid_search();
    test_full_deck();
    test_exhausted();
    test_freeze();
    test_dealer();
    test_hold();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
